// File: rtl/hazard_scoreboard.sv
// Hazard unit for the pipelined MIPS core: a Tnew-countdown scoreboard of in-flight GPR writers
// (E, M, W) drives the D-stage stall and forward selects; an MDU countdown models mult/div busy time.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int TW         = 2,
  parameter int MULT_LAT   = 5,
  parameter int DIV_LAT    = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    d_valid,
  input  logic [NUM_SRC*AW-1:0]   d_src_addr,
  input  logic [NUM_SRC*TW-1:0]   d_src_tuse,
  input  logic                    d_wr_en,
  input  logic [AW-1:0]           d_dst_addr,
  input  logic [TW-1:0]           d_tnew,
  input  logic                    d_md_start,
  input  logic                    d_md_is_div,
  input  logic                    d_uses_hilo,
  output logic                    stall,
  output logic [NUM_SRC*2-1:0]    fwd_sel,
  output logic                    md_busy,
  output logic [31:0]             stall_cnt
);

  localparam logic [TW-1:0] TUSE_NONE = '1;
  localparam int            CW        = $clog2(DIV_LAT + 1);

  typedef struct packed {
    logic          valid;
    logic          wr_en;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
    logic          md_start;
    logic          md_is_div;
  } entry_t;

  entry_t              r_e [NUM_STAGES];
  logic [CW-1:0]       r_md_cnt;
  logic [31:0]         r_stall_cnt;

  logic [NUM_SRC-1:0]  w_stall_src;
  logic [NUM_SRC*2-1:0] w_fwd;
  logic                w_found;
  logic [AW-1:0]       w_src;
  logic [TW-1:0]       w_tuse;
  logic                w_md_issue;
  logic                w_stall_md;
  logic                w_stall;

  // Youngest matching writer wins: scan from E outward and stop at the first hit.
  always_comb begin
    w_stall_src = '0;
    w_fwd       = '0;
    w_found     = 1'b0;
    w_src       = '0;
    w_tuse      = TUSE_NONE;
    for (int s = 0; s < NUM_SRC; s++) begin
      w_found = 1'b0;
      w_src   = d_src_addr[s*AW +: AW];
      w_tuse  = d_src_tuse[s*TW +: TW];
      if (w_tuse != TUSE_NONE) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (!w_found && r_e[k].valid && r_e[k].wr_en &&
              (r_e[k].dst == w_src) && (r_e[k].dst != '0)) begin
            w_found = 1'b1;
            if (r_e[k].tnew > w_tuse) w_stall_src[s] = 1'b1;
            if (r_e[k].tnew == '0) w_fwd[s*2 +: 2] = 2'(k + 1);
          end
        end
      end
    end
  end

  assign w_md_issue = r_e[0].valid & r_e[0].md_start;
  assign md_busy    = (r_md_cnt != '0);
  assign w_stall_md = d_valid & d_uses_hilo & (md_busy | w_md_issue);
  assign w_stall    = d_valid & ((|w_stall_src) | w_stall_md);
  assign stall      = w_stall;
  assign fwd_sel    = w_fwd;
  assign stall_cnt  = r_stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_STAGES; i++) r_e[i] <= '0;
    end else begin
      for (int i = NUM_STAGES - 1; i > 0; i--) begin
        r_e[i]      <= r_e[i-1];
        r_e[i].tnew <= (r_e[i-1].tnew == '0) ? '0 : r_e[i-1].tnew - 1'b1;
      end
      if (d_valid && !w_stall) begin
        r_e[0].valid     <= 1'b1;
        r_e[0].wr_en     <= d_wr_en;
        r_e[0].dst       <= d_dst_addr;
        r_e[0].tnew      <= d_tnew;
        r_e[0].md_start  <= d_md_start;
        r_e[0].md_is_div <= d_md_is_div;
      end else begin
        r_e[0] <= '0;
      end
    end
  end

  // The MDU counter loads while the mult/div sits in E, so HI/LO users also wait out that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_md_issue) r_md_cnt <= r_e[0].md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      else if (r_md_cnt != '0) r_md_cnt <= r_md_cnt - 1'b1;
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule
